det_matrix_loader: RTL and testbench
====================================

Name: det_matrix_loader

Overview:
- Front-end initiator for the 8x8 determinant engine.
- Collects 64 signed-nibble matrix entries one at a time from the board entry logic and assembles them into the engine's 256-bit flat input bus.
- Drives the engine's Start/Ack handshake, captures the 32-bit determinant and measures engine latency in clock cycles.
- Sits between the debounced switch/button logic and the determinant engine.

Parameters:
- N_ENTRIES, 64: matrix entries (8x8, row-major).
- ENTRY_W, 4: bits per entry.
- CYC_W, 24: width of the latency counter.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Entry_Valid  in  1  single-cycle strobe: Entry_Data is the next entry.
- Entry_Data  in  4  entry value.
- Back  in  1  single-cycle strobe: delete the last entry.
- Go  in  1  single-cycle strobe: launch computation.
- Clear  in  1  single-cycle strobe: discard the matrix.
- Eng_Done  in  1  engine q_Done.
- Eng_Det  in  32  engine det output.
- input_arr_flat  out  256  to engine; entry k occupies bits [4k+3:4k], k = row*8 + col.
- Start  out  1  to engine Start.
- Ack  out  1  to engine Ack.
- Entry_Count  out  7  entries currently loaded, 0..64.
- Result  out  32  captured determinant, two's complement.
- Cycles  out  24  cycles from Start assertion to Eng_Done, saturating.
- q_Fill, q_Ready, q_Run, q_Ack, q_Show  out  1 each  one-hot state.

Behaviour:
- General:
  - All outputs are registered.
  - Exactly one q_* is high at any time.
- Reset (Reset=0, asynchronous):
  - State FILL.
  - input_arr_flat=0, Entry_Count=0, Start=0, Ack=0, Result=0, Cycles=0.
  - Takes effect immediately in any state, including mid-RUN. Start and Ack drop without waiting for a clock edge.
- Input priority per cycle: Clear > Back > Go > Entry_Valid.
- FILL:
  - Entry_Valid with count<64: slot[count] <= Entry_Data; count+1.
  - Back with count>0: slot[count-1] <= 0; count-1.
  - Back at count=0: no-op.
  - Entry_Valid with Back in the same cycle: the entry is dropped.
  - When the write makes count=64, the next state is READY (q_Ready high the cycle after the 64th strobe).
  - Go in FILL is ignored.
- READY:
  - Entry_Valid: ignored (no overflow write).
  - Back: slot 63 <= 0, count=63, go to FILL.
  - Go: go to RUN. Start <= 1 and Cycles <= 0 on the same edge.
- RUN:
  - Start held at 1; input_arr_flat frozen.
  - Entry_Valid, Back, Go and Clear are all ignored.
  - Cycles increments by 1 each cycle and holds at 2^CYC_W-1.
  - On sampling Eng_Done=1: Result <= Eng_Det, Start <= 0, Ack <= 1, go to ACK. No Cycles increment on that edge.
- ACK:
  - Ack stays 1 while Eng_Done=1.
  - First cycle Eng_Done samples 0: Ack <= 0, go to SHOW.
  - Clear is ignored.
- SHOW:
  - Result and Cycles held.
  - Go: rerun the same matrix (RUN; Start=1, Cycles reset to 0).
  - Back: slot 63 <= 0, count=63, go to FILL.
  - Entry_Valid: ignored.
- Clear (FILL/READY/SHOW):
  - input_arr_flat <= 0, count <= 0, go to FILL.
  - Result and Cycles are retained until the next capture.
- Entry_Data is stored raw. Signedness is interpreted by the engine, not by this block.

Test Plan:
- Fill: strobe 64 entries forming an identity matrix (0x1 at k=0,9,18,...,63, else 0) -> Entry_Count=64, q_Ready=1 one cycle after the last strobe, input_arr_flat = 1 at nibbles 9i only.
- Run: Go in READY -> Start=1 next cycle. Model asserts Eng_Done after 10 cycles with Eng_Det=32'hFFFF_FFFB -> Result=-5, Cycles=10, Ack=1. Model drops Eng_Done 1 cycle after Ack -> Ack=0, q_Show=1.
- Edit: 3 entries (7,2,5), Back, then entry 9 -> Entry_Count=3, nibbles 0..2 = 7,2,9. Back with Entry_Valid in the same cycle -> count 2, no write.
- Boundaries: 65th strobe in READY ignored. Back in READY -> count 63, slot 63=0, q_Fill. Back at count 0 -> no change.
- Clear in FILL (count=20) -> flat=0, count=0. Clear, Back and Go during RUN -> no effect, Start stays 1.
- Reset pulled low mid-RUN -> Start=0 asynchronously, q_Fill=1, Result=0, flat=0.

Source files
------------

// File: rtl/det_matrix_loader.sv
// Front end of the 8x8 determinant engine: assembles the matrix nibble by
// nibble, runs the Start/Ack handshake, and captures the result and latency.
module det_matrix_loader #(
    parameter int N_ENTRIES = 64,
    parameter int ENTRY_W   = 4,
    parameter int CYC_W     = 24
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           Entry_Valid,
    input  logic [ENTRY_W-1:0]             Entry_Data,
    input  logic                           Back,
    input  logic                           Go,
    input  logic                           Clear,
    input  logic                           Eng_Done,
    input  logic [31:0]                    Eng_Det,
    output logic [N_ENTRIES*ENTRY_W-1:0]   input_arr_flat,
    output logic                           Start,
    output logic                           Ack,
    output logic [$clog2(N_ENTRIES+1)-1:0] Entry_Count,
    output logic [31:0]                    Result,
    output logic [CYC_W-1:0]               Cycles,
    output logic                           q_Fill,
    output logic                           q_Ready,
    output logic                           q_Run,
    output logic                           q_Ack,
    output logic                           q_Show
);

    localparam int CNT_W  = $clog2(N_ENTRIES + 1);
    localparam int IDX_W  = $clog2(N_ENTRIES);
    localparam int FLAT_W = N_ENTRIES * ENTRY_W;

    // One-hot encoding so each q_* output is a flop bit.
    typedef enum logic [4:0] {
        FILL  = 5'b00001,
        READY = 5'b00010,
        RUN   = 5'b00100,
        ACKS  = 5'b01000,
        SHOW  = 5'b10000
    } state_t;

    state_t              state_q;
    logic [FLAT_W-1:0]   flat_q;
    logic [CNT_W-1:0]    count_q;
    logic [31:0]         result_q;
    logic [CYC_W-1:0]    cycles_q;
    logic                start_q;
    logic                ack_q;

    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    bk_idx;
    logic [CNT_W-1:0]    count_inc_d;
    logic [CNT_W-1:0]    count_dec_d;
    logic [CYC_W-1:0]    cycles_d;
    logic                last_wr;
    logic                not_full;

    always_comb begin
        wr_idx      = count_q[IDX_W-1:0];
        bk_idx      = wr_idx - 1'b1;
        count_inc_d = count_q + CNT_W'(1);
        count_dec_d = count_q - CNT_W'(1);
        not_full    = (count_q < CNT_W'(N_ENTRIES));
        last_wr     = (count_q == CNT_W'(N_ENTRIES - 1));
        // Latency counter saturates instead of wrapping.
        cycles_d    = (&cycles_q) ? cycles_q : cycles_q + CYC_W'(1);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= FILL;
            flat_q   <= '0;
            count_q  <= '0;
            result_q <= '0;
            cycles_q <= '0;
            start_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (Clear) begin
                        flat_q  <= '0;
                        count_q <= '0;
                    end else if (Back) begin
                        if (count_q != '0) begin
                            flat_q[bk_idx*ENTRY_W +: ENTRY_W] <= '0;
                            count_q <= count_dec_d;
                        end
                    end else if (Go) begin
                        state_q <= FILL;
                    end else if (Entry_Valid && not_full) begin
                        flat_q[wr_idx*ENTRY_W +: ENTRY_W] <= Entry_Data;
                        count_q <= count_inc_d;
                        if (last_wr) state_q <= READY;
                    end
                end
                READY: begin
                    if (Clear) begin
                        flat_q  <= '0;
                        count_q <= '0;
                        state_q <= FILL;
                    end else if (Back) begin
                        flat_q[FLAT_W-1 -: ENTRY_W] <= '0;
                        count_q <= CNT_W'(N_ENTRIES - 1);
                        state_q <= FILL;
                    end else if (Go) begin
                        start_q  <= 1'b1;
                        cycles_q <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (Eng_Done) begin
                        result_q <= Eng_Det;
                        start_q  <= 1'b0;
                        ack_q    <= 1'b1;
                        state_q  <= ACKS;
                    end else begin
                        cycles_q <= cycles_d;
                    end
                end
                ACKS: begin
                    if (!Eng_Done) begin
                        ack_q   <= 1'b0;
                        state_q <= SHOW;
                    end
                end
                SHOW: begin
                    if (Clear) begin
                        flat_q  <= '0;
                        count_q <= '0;
                        state_q <= FILL;
                    end else if (Back) begin
                        flat_q[FLAT_W-1 -: ENTRY_W] <= '0;
                        count_q <= CNT_W'(N_ENTRIES - 1);
                        state_q <= FILL;
                    end else if (Go) begin
                        start_q  <= 1'b1;
                        cycles_q <= '0;
                        state_q  <= RUN;
                    end
                end
                default: begin
                    state_q <= FILL;
                    start_q <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign input_arr_flat = flat_q;
    assign Start          = start_q;
    assign Ack            = ack_q;
    assign Entry_Count    = count_q;
    assign Result         = result_q;
    assign Cycles         = cycles_q;
    assign q_Fill         = state_q[0];
    assign q_Ready        = state_q[1];
    assign q_Run          = state_q[2];
    assign q_Ack          = state_q[3];
    assign q_Show         = state_q[4];

endmodule

// File: tb/tb_det_matrix_loader.sv
// Directed bench for det_matrix_loader: table-driven edit vectors plus
// hand-written fill / run / reset sequences.
module tb_det_matrix_loader;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Entry_Valid = 1'b0;
    logic [3:0]   Entry_Data = '0;
    logic         Back = 1'b0;
    logic         Go = 1'b0;
    logic         Clear = 1'b0;
    logic         Eng_Done = 1'b0;
    logic [31:0]  Eng_Det = '0;
    logic [255:0] input_arr_flat;
    logic         Start, Ack;
    logic [6:0]   Entry_Count;
    logic [31:0]  Result;
    logic [23:0]  Cycles;
    logic         q_Fill, q_Ready, q_Run, q_Ack, q_Show;

    localparam logic [4:0] S_FILL  = 5'b00001;
    localparam logic [4:0] S_READY = 5'b00010;
    localparam logic [4:0] S_RUN   = 5'b00100;
    localparam logic [4:0] S_ACK   = 5'b01000;
    localparam logic [4:0] S_SHOW  = 5'b10000;

    int n_run  = 0;
    int n_fail = 0;

    det_matrix_loader dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Entry_Valid    (Entry_Valid),
        .Entry_Data     (Entry_Data),
        .Back           (Back),
        .Go             (Go),
        .Clear          (Clear),
        .Eng_Done       (Eng_Done),
        .Eng_Det        (Eng_Det),
        .input_arr_flat (input_arr_flat),
        .Start          (Start),
        .Ack            (Ack),
        .Entry_Count    (Entry_Count),
        .Result         (Result),
        .Cycles         (Cycles),
        .q_Fill         (q_Fill),
        .q_Ready        (q_Ready),
        .q_Run          (q_Run),
        .q_Ack          (q_Ack),
        .q_Show         (q_Show)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       ev;
        logic [3:0] d;
        logic       bk;
        logic       go;
        logic       cl;
        logic [6:0] cnt;
        logic [15:0] lo;
        logic [4:0] st;
    } vec_t;

    vec_t tv[10];

    function automatic logic [4:0] st();
        return {q_Show, q_Ack, q_Run, q_Ready, q_Fill};
    endfunction

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic ev, input logic [3:0] d,
                        input logic bk, input logic go, input logic cl);
        Entry_Valid = ev;
        Entry_Data  = d;
        Back        = bk;
        Go          = go;
        Clear       = cl;
        @(posedge Clk);
        #1;
        Entry_Valid = 1'b0;
        Entry_Data  = '0;
        Back        = 1'b0;
        Go          = 1'b0;
        Clear       = 1'b0;
    endtask

    logic [255:0] exp_flat;

    initial begin
        tv[0] = '{1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 7'd1, 16'h0007, S_FILL};
        tv[1] = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 7'd2, 16'h0027, S_FILL};
        tv[2] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 7'd3, 16'h0527, S_FILL};
        tv[3] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 7'd2, 16'h0027, S_FILL};
        tv[4] = '{1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 7'd3, 16'h0927, S_FILL};
        tv[5] = '{1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 7'd2, 16'h0027, S_FILL};
        tv[6] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 7'd1, 16'h0007, S_FILL};
        tv[7] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0000, S_FILL};
        tv[8] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0000, S_FILL};
        tv[9] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 7'd0, 16'h0000, S_FILL};

        // Reset state
        #12;
        chk("rst_state", 256'(st()), 256'(S_FILL));
        chk("rst_flat", input_arr_flat, '0);
        chk("rst_count", 256'(Entry_Count), 0);
        chk("rst_start_ack", 256'({Start, Ack}), 0);
        chk("rst_res_cyc", 256'({Result, Cycles}), 0);
        @(negedge Clk);
        Reset = 1'b1;

        // Edit vectors
        for (int i = 0; i < 10; i++) begin
            step(tv[i].ev, tv[i].d, tv[i].bk, tv[i].go, tv[i].cl);
            chk($sformatf("edit%0d_cnt", i), 256'(Entry_Count),
                256'(tv[i].cnt));
            chk($sformatf("edit%0d_lo", i), 256'(input_arr_flat[15:0]),
                256'(tv[i].lo));
            chk($sformatf("edit%0d_st", i), 256'(st()), 256'(tv[i].st));
        end

        // Clear in FILL with 20 entries
        for (int k = 0; k < 20; k++) step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        chk("clr_pre_cnt", 256'(Entry_Count), 20);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("clr_flat", input_arr_flat, '0);
        chk("clr_cnt", 256'(Entry_Count), 0);

        // Identity fill
        exp_flat = '0;
        for (int k = 0; k < 64; k++) begin
            if (k % 9 == 0) exp_flat[4*k] = 1'b1;
            step(1'b1, (k % 9 == 0) ? 4'h1 : 4'h0, 1'b0, 1'b0, 1'b0);
            if (k == 62) chk("fill63_st", 256'(st()), 256'(S_FILL));
        end
        chk("fill_cnt", 256'(Entry_Count), 64);
        chk("fill_st", 256'(st()), 256'(S_READY));
        chk("fill_flat", input_arr_flat, exp_flat);

        // 65th strobe ignored, Back in READY, refill
        step(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("ovf_cnt", 256'(Entry_Count), 64);
        chk("ovf_flat", input_arr_flat, exp_flat);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("rdy_back_cnt", 256'(Entry_Count), 63);
        chk("rdy_back_st", 256'(st()), 256'(S_FILL));
        chk("rdy_back_s63", 256'(input_arr_flat[255:252]), 0);
        step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        chk("refill_st", 256'(st()), 256'(S_READY));
        chk("refill_flat", input_arr_flat, exp_flat);

        // Run: Eng_Done sampled on the 11th edge after Go
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("go_start", 256'(Start), 1);
        chk("go_st", 256'(st()), 256'(S_RUN));
        chk("go_cyc", 256'(Cycles), 0);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
        chk("run_ign_start", 256'(Start), 1);
        chk("run_ign_st", 256'(st()), 256'(S_RUN));
        chk("run_ign_cnt", 256'(Entry_Count), 64);
        chk("run_ign_flat", input_arr_flat, exp_flat);
        for (int k = 0; k < 7; k++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("run_cyc10", 256'(Cycles), 10);
        Eng_Done = 1'b1;
        Eng_Det  = 32'hFFFF_FFFB;
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        Eng_Det  = 32'h0;
        chk("cap_res", 256'(Result), 256'(32'hFFFF_FFFB));
        chk("cap_cyc", 256'(Cycles), 10);
        chk("cap_ack", 256'({Start, Ack}), 256'(2'b01));
        chk("cap_st", 256'(st()), 256'(S_ACK));
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("ackhold_ack", 256'(Ack), 1);
        chk("ackhold_st", 256'(st()), 256'(S_ACK));
        chk("ackhold_cnt", 256'(Entry_Count), 64);
        Eng_Done = 1'b0;
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("show_ack", 256'(Ack), 0);
        chk("show_st", 256'(st()), 256'(S_SHOW));
        chk("show_res", 256'(Result), 256'(32'hFFFF_FFFB));
        step(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        chk("show_ev_ign", input_arr_flat, exp_flat);

        // Rerun, then asynchronous reset mid-RUN
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("rerun_start", 256'(Start), 1);
        chk("rerun_cyc0", 256'(Cycles), 0);
        for (int k = 0; k < 3; k++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("rerun_cyc3", 256'(Cycles), 3);
        #2;
        Reset = 1'b0;
        #2;
        chk("arst_start", 256'(Start), 0);
        chk("arst_st", 256'(st()), 256'(S_FILL));
        chk("arst_res", 256'(Result), 0);
        chk("arst_flat", input_arr_flat, '0);
        chk("arst_cnt_cyc", 256'({Entry_Count, Cycles}), 0);
        @(negedge Clk);
        Reset = 1'b1;
        step(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        chk("post_rst_lo", 256'(input_arr_flat[15:0]), 256'(16'h000A));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
